mac16_dot_seq: RTL and testbench

- Upstream sequencer for the 16x16 multiply-accumulate block.
- Accepts a stream of 16-bit operand pairs on a valid/ready interface and drives the MAC operand ports and hold lines.
- Drives the MAC accumulator controls (hold, load, add/sub) so that LEN products are summed into the 32-bit accumulator.
- Captures the final 32-bit MAC output and presents it as a one-shot result.

---
 rtl/mac16_dot_seq_if.sv | 37 +++
 rtl/mac16_dot_seq.sv | 123 ++++++++++++
 tb/tb_mac16_dot_seq.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac16_dot_seq_if.sv
// Operand stream, job control and MAC-side bus of the dot-product sequencer.
// The master side drives jobs and operands and returns MAC_O; the slave side is the sequencer.
interface mac16_dot_seq_if #(parameter int LEN_W = 8);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             s_valid;
    logic             s_ready;
    logic [15:0]      s_a;
    logic [15:0]      s_b;
    logic             s_sub;
    logic [15:0]      a_out;
    logic [15:0]      b_out;
    logic             ahld;
    logic             bhld;
    logic             ohhld;
    logic             olhld;
    logic             ohlda;
    logic             ollda;
    logic             ohads;
    logic             olads;
    logic [31:0]      mac_o;
    logic [31:0]      res;
    logic             res_valid;
    logic             busy;

    modport master (
        output start, len, s_valid, s_a, s_b, s_sub, mac_o,
        input  s_ready, a_out, b_out, ahld, bhld, ohhld, olhld,
               ohlda, ollda, ohads, olads, res, res_valid, busy
    );

    modport slave (
        input  start, len, s_valid, s_a, s_b, s_sub, mac_o,
        output s_ready, a_out, b_out, ahld, bhld, ohhld, olhld,
               ohlda, ollda, ohads, olads, res, res_valid, busy
    );
endinterface

// File: rtl/mac16_dot_seq.sv
// Sequencer feeding a 16x16 MAC: streams LEN operand pairs, drives the accumulator
// load/add/sub/hold lines through a MAC_LAT-deep control pipe and captures the sum.
module mac16_dot_seq #(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    mac16_dot_seq_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, CAPT, DONE} state_t;

    typedef struct packed {
        logic first;
        logic last;
        logic sub;
    } ctl_t;

    state_t               state, state_nxt;
    logic [LEN_W-1:0]     rem;
    logic                 first_pend;
    logic                 hs;
    logic                 s_ready, busy, res_valid;
    logic [15:0]          a_q, b_q;
    logic [31:0]          res_q;
    logic [MAC_LAT:0]     vld_pipe;
    ctl_t [MAC_LAT:0]     ctl_pipe;
    logic                 pc_vld;
    ctl_t                 pc;

    assign hs     = bus.s_valid & s_ready;
    assign pc_vld = vld_pipe[MAC_LAT];
    assign pc     = ctl_pipe[MAC_LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = (bus.len != '0) ? RUN : DONE;
            RUN: begin
                busy    = 1'b1;
                s_ready = (rem != '0);
                if (hs && rem == LEN_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pc_vld && pc.last) state_nxt = CAPT;
            end
            CAPT: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job bookkeeping and result capture; a zero-length job reports 0 without touching the MAC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem        <= '0;
            first_pend <= 1'b0;
            res_q      <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                rem        <= bus.len;
                first_pend <= 1'b1;
                if (bus.len == '0) res_q <= '0;
            end else if (hs) begin
                rem        <= rem - LEN_W'(1);
                first_pend <= 1'b0;
            end
            if (state == CAPT) res_q <= bus.mac_o;
        end
    end

    // Operand stage p0 and the control shift register down to the accumulator stage pC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q      <= '0;
            b_q      <= '0;
            vld_pipe <= '0;
            ctl_pipe <= '0;
        end else begin
            if (hs) begin
                a_q <= bus.s_a;
                b_q <= bus.s_b;
            end
            vld_pipe[0] <= hs;
            ctl_pipe[0] <= '{first: first_pend, last: (rem == LEN_W'(1)), sub: bus.s_sub};
            for (int i = 1; i <= MAC_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                ctl_pipe[i] <= ctl_pipe[i-1];
            end
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.busy      = busy;
    assign bus.res_valid = res_valid;
    assign bus.res       = res_q;
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.ahld      = ~vld_pipe[0];
    assign bus.bhld      = ~vld_pipe[0];
    assign bus.ohhld     = ~pc_vld;
    assign bus.olhld     = ~pc_vld;
    // The first product of a job is always loaded positive, whatever its sub flag says.
    assign bus.ohlda     = pc_vld & pc.first;
    assign bus.ollda     = pc_vld & pc.first;
    assign bus.ohads     = pc_vld & pc.sub & ~pc.first;
    assign bus.olads     = pc_vld & pc.sub & ~pc.first;
endmodule

// File: tb/tb_mac16_dot_seq.sv
// Directed bench for mac16_dot_seq with a behavioural signed 16x16 MAC (input regs with
// hold, 32-bit modulo accumulator) closing the loop on MAC_O.
module tb_mac16_dot_seq;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    mac16_dot_seq_if #(.LEN_W(8)) bus ();

    mac16_dot_seq #(.LEN_W(8), .MAC_LAT(1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MAC model: operands latched when holds drop, product lands in the accumulator one cycle later.
    logic [15:0] areg = '0;
    logic [15:0] breg = '0;
    logic [31:0] acc  = '0;
    logic [31:0] prod;
    bit          pair_diff = 1'b0;

    assign prod      = {{16{areg[15]}}, areg} * {{16{breg[15]}}, breg};
    assign bus.mac_o = acc;

    always @(posedge clk) begin
        if (!bus.ahld) areg <= bus.a_out;
        if (!bus.bhld) breg <= bus.b_out;
        if (!bus.olhld)
            acc <= bus.ollda ? (bus.olads ? -prod : prod)
                             : (bus.olads ? acc - prod : acc + prod);
    end

    always @(negedge clk) begin
        if (bus.ohhld !== bus.olhld || bus.ohlda !== bus.ollda ||
            bus.ohads !== bus.olads || bus.ahld !== bus.bhld)
            pair_diff = 1'b1;
    end

    logic [15:0] va [16];
    logic [15:0] vb [16];
    bit          vs [16];

    task automatic do_job(input int len, input bit bubbles, input bit spam,
                          output logic [31:0] r, output int lat, output int ld_cnt,
                          output bit ld_first, output int ctl_cnt, output int hold_mid,
                          output int busy_gap, output int act, output bit tmo);
        int idx, cyc, hs_cyc;
        bit tog;
        r = 'x; lat = -1; ld_cnt = 0; ld_first = 0; ctl_cnt = 0; hold_mid = 0;
        busy_gap = 0; act = 0; tmo = 1; idx = 0; cyc = 0; hs_cyc = 0; tog = 1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len   = 8'(len);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (bus.res_valid) begin
                r   = bus.res;
                lat = cyc - hs_cyc;
                tmo = 0;
                break;
            end
            if (!bus.busy) busy_gap++;
            if (!bus.ahld || !bus.olhld) act++;
            if (!bus.olhld) begin
                if (ctl_cnt == 0) ld_first = bus.ollda;
                ctl_cnt++;
            end else if (ctl_cnt > 0 && ctl_cnt < len) begin
                hold_mid++;
            end
            if (bus.ollda) ld_cnt++;
            bus.start   = spam && bus.busy;
            bus.len     = 8'd1;
            bus.s_valid = (idx < len) && (!bubbles || tog);
            tog = !tog;
            if (idx < len) begin
                bus.s_a   = va[idx];
                bus.s_b   = vb[idx];
                bus.s_sub = vs[idx];
            end
            if (bus.s_valid && bus.s_ready) begin
                idx++;
                hs_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.start   = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.s_ready, bus.res_valid, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 000", {bus.s_ready, bus.res_valid, bus.busy});
        end
        checks++;
        if ({bus.ahld, bus.bhld, bus.ohhld, bus.olhld} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_holds got %b exp 1111", {bus.ahld, bus.bhld, bus.ohhld, bus.olhld});
        end
        checks++;
        if ({bus.ohlda, bus.ollda, bus.ohads, bus.olads} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 0000", {bus.ohlda, bus.ollda, bus.ohads, bus.olads});
        end
        checks++;
        if ({bus.a_out, bus.b_out, bus.res} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {bus.a_out, bus.b_out, bus.res});
        end
        rstn = 1'b1;
    endtask

    task automatic test_basic;
        logic [31:0] r; int lat, ld, ctl, hm, bg, act; bit lf, tmo;
        va[0] = 16'd2;    vb[0] = 16'd3; vs[0] = 0;
        va[1] = 16'd4;    vb[1] = 16'd5; vs[1] = 0;
        va[2] = 16'hFFFF; vb[2] = 16'd7; vs[2] = 0;
        do_job(3, 0, 0, r, lat, ld, lf, ctl, hm, bg, act, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL basic_timeout no res_valid"); end
        checks++;
        if (r !== 32'h0000_0013) begin errors++; $display("FAIL basic_res got %h exp 00000013", r); end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", lat); end
        checks++;
        if (ld != 1 || lf !== 1'b1) begin
            errors++;
            $display("FAIL basic_load got cnt=%0d first=%0b exp cnt=1 first=1", ld, lf);
        end
    endtask

    task automatic test_sub;
        logic [31:0] r; int lat, ld, ctl, hm, bg, act; bit lf, tmo;
        for (int i = 0; i < 4; i++) begin va[i] = 16'd100; vb[i] = 16'd100; vs[i] = i[0]; end
        do_job(4, 0, 0, r, lat, ld, lf, ctl, hm, bg, act, tmo);
        checks++;
        if (tmo || r !== 32'h0) begin errors++; $display("FAIL sub_alt got %h exp 00000000", r); end
        vs[0] = 1;
        do_job(4, 0, 0, r, lat, ld, lf, ctl, hm, bg, act, tmo);
        checks++;
        if (tmo || r !== 32'h0) begin errors++; $display("FAIL sub_first_ignored got %h exp 00000000", r); end
    endtask

    task automatic test_bubbles;
        logic [31:0] r; int lat, ld, ctl, hm, bg, act; bit lf, tmo;
        va[0] = 16'd1; vb[0] = 16'd2; vs[0] = 0;
        va[1] = 16'd3; vb[1] = 16'd4; vs[1] = 0;
        va[2] = 16'd5; vb[2] = 16'd6; vs[2] = 0;
        va[3] = 16'd7; vb[3] = 16'd8; vs[3] = 0;
        va[4] = 16'hFFFE; vb[4] = 16'd9; vs[4] = 0;
        do_job(5, 1, 0, r, lat, ld, lf, ctl, hm, bg, act, tmo);
        checks++;
        if (tmo || r !== 32'd82) begin errors++; $display("FAIL bubble_res got %h exp 00000052", r); end
        checks++;
        if (hm != 4) begin errors++; $display("FAIL bubble_holds got %0d exp 4", hm); end
        checks++;
        if (ctl != 5) begin errors++; $display("FAIL bubble_ctl_cycles got %0d exp 5", ctl); end
        checks++;
        if (bg != 0) begin errors++; $display("FAIL bubble_busy_gaps got %0d exp 0", bg); end
    endtask

    task automatic test_len0_and_start_ignored;
        logic [31:0] r; int lat, ld, ctl, hm, bg, act; bit lf, tmo;
        do_job(0, 0, 0, r, lat, ld, lf, ctl, hm, bg, act, tmo);
        checks++;
        if (tmo || r !== 32'h0) begin errors++; $display("FAIL len0_res got %h exp 00000000", r); end
        checks++;
        if (lat != 0) begin errors++; $display("FAIL len0_latency got %0d exp 0", lat); end
        checks++;
        if (act != 0) begin errors++; $display("FAIL len0_mac_activity got %0d exp 0", act); end
        va[0] = 16'd5; vb[0] = 16'd5; vs[0] = 0;
        va[1] = 16'd6; vb[1] = 16'd6; vs[1] = 0;
        do_job(2, 0, 1, r, lat, ld, lf, ctl, hm, bg, act, tmo);
        checks++;
        if (tmo || r !== 32'd61) begin errors++; $display("FAIL start_ignored got %h exp 0000003d", r); end
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_ignored_idle busy=%b exp 0", bus.busy); end
    endtask

    task automatic test_wrap;
        logic [31:0] r; int lat, ld, ctl, hm, bg, act; bit lf, tmo;
        for (int i = 0; i < 3; i++) begin va[i] = 16'h7FFF; vb[i] = 16'h7FFF; vs[i] = 0; end
        do_job(3, 0, 0, r, lat, ld, lf, ctl, hm, bg, act, tmo);
        checks++;
        if (tmo || r !== 32'hBFFD_0003) begin errors++; $display("FAIL wrap_res got %h exp bffd0003", r); end
    endtask

    task automatic test_reset_mid_job;
        logic [31:0] r; int lat, ld, ctl, hm, bg, act, stray; bit lf, tmo;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.len = 8'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1; bus.s_a = 16'd10 + 16'(i); bus.s_b = 16'd3; bus.s_sub = 1'b0;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.s_ready, bus.res_valid, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_strobes got %b exp 000", {bus.s_ready, bus.res_valid, bus.busy});
        end
        checks++;
        if ({bus.ahld, bus.bhld, bus.ohhld, bus.olhld} !== 4'b1111) begin
            errors++;
            $display("FAIL midrst_holds got %b exp 1111", {bus.ahld, bus.bhld, bus.ohhld, bus.olhld});
        end
        checks++;
        if ({bus.ollda, bus.olads, bus.a_out, bus.b_out, bus.res} !== 66'h0) begin
            errors++;
            $display("FAIL midrst_data got %h exp 0", {bus.ollda, bus.olads, bus.a_out, bus.b_out, bus.res});
        end
        repeat (2) @(posedge clk);
        #1;
        rstn  = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.res_valid || !bus.olhld || bus.busy) stray++;
            @(posedge clk); #1;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midrst_stray got %0d exp 0", stray); end
        va[0] = 16'd3; vb[0] = 16'd3; vs[0] = 0;
        do_job(1, 0, 0, r, lat, ld, lf, ctl, hm, bg, act, tmo);
        checks++;
        if (tmo || r !== 32'd9) begin errors++; $display("FAIL midrst_rerun got %h exp 00000009", r); end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL midrst_latency got %0d exp 4", lat); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r; int lat, ld, ctl, hm, bg, act; bit lf, tmo;
        va[0] = 16'd1; vb[0] = 16'd1; vs[0] = 0;
        va[1] = 16'd2; vb[1] = 16'd2; vs[1] = 0;
        do_job(2, 0, 0, r, lat, ld, lf, ctl, hm, bg, act, tmo);
        checks++;
        if (tmo || r !== 32'd5) begin errors++; $display("FAIL b2b_first got %h exp 00000005", r); end
        va[0] = 16'd7; vb[0] = 16'hFFFF; vs[0] = 0;
        do_job(1, 0, 0, r, lat, ld, lf, ctl, hm, bg, act, tmo);
        checks++;
        if (tmo || r !== 32'hFFFF_FFF9) begin errors++; $display("FAIL b2b_second got %h exp fffffff9", r); end
        checks++;
        if (pair_diff) begin errors++; $display("FAIL paired_lines got diverged exp identical"); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.start = 1'b0; bus.len = '0; bus.s_valid = 1'b0;
        bus.s_a = '0; bus.s_b = '0; bus.s_sub = 1'b0;
        test_reset;
        test_basic;
        test_sub;
        test_bubbles;
        test_len0_and_start_ignored;
        test_wrap;
        test_reset_mid_job;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
